// File: rtl/gnr_pkg.sv
// Shared types and default constants for the GNR attractor sequencing controller.
package gnr_pkg;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STEP = 3'd2,
    ST_CMP  = 3'd3,
    ST_OUT  = 3'd4,
    ST_NEXT = 3'd5
  } gnr_state_e;

  // Default sizing of the node array and the step counter.
  localparam int GNR_N_NODES   = 8;
  localparam int GNR_STEP_W    = 16;
  localparam int GNR_MAX_STEPS = 1024;

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Result port of the attractor controller: valid/ready handshake plus payload.
interface gnr_attractor_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int STEP_W  = 16
);

  logic               res_valid;
  logic               res_ready;
  logic [N_NODES-1:0] res_init;
  logic [STEP_W-1:0]  res_steps;
  logic               res_timeout;

  // Controller side produces the result.
  modport master (
    output res_valid,
    input  res_ready,
    output res_init,
    output res_steps,
    output res_timeout
  );

  // Consumer side accepts the result.
  modport slave (
    input  res_valid,
    output res_ready,
    input  res_init,
    input  res_steps,
    input  res_timeout
  );

endinterface

// File: rtl/gnr_state_cmp.sv
// Floyd comparison of the slow and fast node state copies. A match is only
// meaningful on an even step count, when the fast copy has taken exactly
// twice as many updates as the slow copy.
module gnr_state_cmp #(
  parameter int N_NODES = 8
) (
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  input  logic               steps_lsb,
  output logic               match
);

  // Pure combinational equality qualified by the even-step condition.
  always_comb begin
    match = 1'b0;
    if ((s0_vec == s1_vec) && (steps_lsb == 1'b0)) begin
      match = 1'b1;
    end else begin
      match = 1'b0;
    end
  end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Sequencing controller for the GNR node array: walks a range of initial
// states, steps the slow/fast copies, detects an attractor and reports the
// initial state and step count over a valid/ready result port.
module gnr_attractor_ctrl
  import gnr_pkg::*;
#(
  parameter int N_NODES   = GNR_N_NODES,
  parameter int STEP_W    = GNR_STEP_W,
  parameter int MAX_STEPS = GNR_MAX_STEPS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] init_base,
  input  logic [N_NODES:0]   init_count,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               busy,
  output logic               done,
  gnr_attractor_ctrl_if.master res
);

  localparam logic [STEP_W-1:0]  MAX_STEPS_C = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0]  STEP_ONE    = STEP_W'(1'b1);
  localparam logic [N_NODES:0]   REM_ONE     = (N_NODES + 1)'(1'b1);
  localparam logic [N_NODES-1:0] CUR_ONE     = N_NODES'(1'b1);

  gnr_state_e         state_r;
  gnr_state_e         state_s;
  logic               done_s;
  logic               busy_s;
  logic               match_s;

  logic [N_NODES-1:0] cur_r;
  logic [N_NODES:0]   remaining_r;
  logic [STEP_W-1:0]  steps_r;

  logic               reset_nos_r;
  logic               strobe_r;
  logic               res_valid_r;
  logic [N_NODES-1:0] res_init_r;
  logic [STEP_W-1:0]  res_steps_r;
  logic               res_timeout_r;
  logic               done_r;
  logic               busy_r;

  gnr_state_cmp #(
    .N_NODES (N_NODES)
  ) u_cmp (
    .s0_vec    (s0_vec),
    .s1_vec    (s1_vec),
    .steps_lsb (steps_r[0]),
    .match     (match_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (init_count != '0) begin
            state_s = ST_LOAD;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_STEP;
      ST_STEP: state_s = ST_CMP;
      ST_CMP: begin
        if (match_s) begin
          state_s = ST_OUT;
        end else if (steps_r == MAX_STEPS_C) begin
          state_s = ST_OUT;
        end else begin
          state_s = ST_STEP;
        end
      end
      ST_OUT: begin
        if (res.res_ready) begin
          state_s = ST_NEXT;
          if (remaining_r == REM_ONE) begin
            done_s = 1'b1;
          end else begin
            done_s = 1'b0;
          end
        end else begin
          state_s = ST_OUT;
        end
      end
      ST_NEXT: begin
        if (remaining_r == REM_ONE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    // Busy drops together with the done pulse of the last init.
    busy_s = (state_s != ST_IDLE) && !done_s;
  end

  // State register and registered strobes, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      reset_nos_r <= 1'b0;
      strobe_r    <= 1'b0;
      res_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      reset_nos_r <= (state_s == ST_LOAD);
      strobe_r    <= (state_s == ST_STEP);
      res_valid_r <= (state_s == ST_OUT);
      done_r      <= done_s;
      busy_r      <= busy_s;
    end
  end

  // Datapath: current init, remaining count, step counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_r         <= '0;
      remaining_r   <= '0;
      steps_r       <= '0;
      res_init_r    <= '0;
      res_steps_r   <= '0;
      res_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (init_count != '0)) begin
            cur_r       <= init_base;
            remaining_r <= init_count;
          end
        end
        ST_LOAD: steps_r <= '0;
        ST_STEP: steps_r <= steps_r + STEP_ONE;
        ST_CMP: begin
          if (state_s == ST_OUT) begin
            res_init_r    <= cur_r;
            res_steps_r   <= steps_r;
            res_timeout_r <= ~match_s;
          end
        end
        ST_NEXT: begin
          remaining_r <= remaining_r - REM_ONE;
          if (remaining_r != REM_ONE) begin
            cur_r <= cur_r + CUR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign reset_nos       = reset_nos_r;
  assign start_s0        = strobe_r;
  assign start_s1        = strobe_r;
  assign init_state      = cur_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign res.res_valid   = res_valid_r;
  assign res.res_init    = res_init_r;
  assign res.res_steps   = res_steps_r;
  assign res.res_timeout = res_timeout_r;

endmodule

// File: doc/gnr_attractor_ctrl.md
Name: gnr_attractor_ctrl

Overview:
- Sequencing controller sitting directly upstream of the GNR node array (gsk3b and sibling nodes).
- For each initial state in a programmed range, it loads the nodes and steps the two state copies: s0 is the slow copy, updated on every second start_s0; s1 is the fast copy, updated on every start_s1.
- It compares the packed s0/s1 vectors Floyd-style to detect an attractor, then reports the initial state and step count over a valid/ready result port.

Parameters:
- N_NODES, 8: number of network nodes; width of the init/state vectors.
- STEP_W, 16: width of the step counter and of res_steps.
- MAX_STEPS, 1024: step limit; reaching it ends the run with timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a batch; ignored while busy.
- init_base  in  N_NODES  first initial state; sampled on start.
- init_count  in  N_NODES+1  number of initial states; sampled on start; 0 means done immediately.
- reset_nos  out  1  one-cycle node load strobe.
- start_s0  out  1  step strobe for the slow copy.
- start_s1  out  1  step strobe for the fast copy.
- init_state  out  N_NODES  bit i drives node i's init_state.
- s0_vec  in  N_NODES  packed s0 outputs of the nodes.
- s1_vec  in  N_NODES  packed s1 outputs of the nodes.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_init  out  N_NODES  initial state of this result.
- res_steps  out  STEP_W  start pulses issued when the match occurred.
- res_timeout  out  1  1 = MAX_STEPS reached without a match.
- busy  out  1  batch in progress.
- done  out  1  one-cycle pulse when the batch completes.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counters 0.
- States: IDLE, LOAD, STEP, CMP, OUT, NEXT.
- IDLE:
  - On start with init_count!=0: latch cur=init_base, remaining=init_count; busy=1; go to LOAD.
  - On start with init_count==0: done pulses the next cycle; busy stays 0.
- LOAD: reset_nos=1 for exactly one cycle; init_state=cur (held stable through the whole run); steps=0; go to STEP.
- STEP:
  - start_s0=start_s1=1 for one cycle; steps<=steps+1; go to CMP.
  - Node registers update on this edge.
- CMP (node outputs now reflect the step):
  - Compare only when steps is even, since then the fast copy has 2m updates and the slow copy m.
  - Even steps and s0_vec==s1_vec: res_timeout=0, go to OUT.
  - Otherwise, steps==MAX_STEPS: res_timeout=1, go to OUT.
  - Otherwise: go back to STEP.
  - Per step: 2 cycles.
- OUT:
  - res_valid=1; res_init=cur; res_steps=steps.
  - All result fields held stable while res_ready=0; no node strobes issued.
  - Transfer on res_valid&&res_ready; res_valid drops the next cycle; go to NEXT.
- NEXT:
  - remaining-1.
  - If 0: done=1 for one cycle, busy=0, go to IDLE.
  - Else: cur<=cur+1 (wraps mod 2^N_NODES), go to LOAD.
- Mutual exclusion: reset_nos is never asserted in the same cycle as start_s0/start_s1.
- Strobes: start_s0 and start_s1 are always asserted together.
- start asserted while busy is ignored and not queued.
- MAX_STEPS odd: the timeout check still fires on the odd count; a match is never declared on an odd count.
- rst_n low mid-run: aborts immediately; no done pulse and no partial result.
- Latency per init: 1 (LOAD) + 2*res_steps + OUT handshake cycles + 1 (NEXT).

Decomposition:
- Package gnr_pkg:
  - FSM state enum (3-bit encoding).
  - Default constants for N_NODES, STEP_W, MAX_STEPS.
- One sub-module, gnr_state_cmp: registered-free equality of s0_vec/s1_vec plus the even-step qualifier. It produces match.
- The FSM and counters remain in gnr_attractor_ctrl.

Test Plan:
- Identity-stub nodes (next=state), init_base=8'h5A, init_count=1 -> one LOAD with init_state=8'h5A; result res_init=8'h5A, res_steps=2, res_timeout=0; done pulse one cycle after the handshake.
- Inverter-stub nodes (next=~state), init_base=8'h00 -> no match at step 2; match at step 4; res_steps=4, res_timeout=0.
- Stub forcing s0_vec!=s1_vec, MAX_STEPS=6 -> res_steps=6, res_timeout=1; exactly 6 start_s1 pulses.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid stays 1, fields stable, no reset_nos/start_s* pulses; release -> exactly one transfer.
- Batch with wrap: init_base=8'hFE, init_count=3 -> results with res_init FE, FF, 00 in order, then a single done; a start issued mid-batch is ignored.
- rst_n pulsed low during STEP -> all outputs 0 asynchronously; FSM back in IDLE; a fresh start runs normally; init_count=0 -> done pulse with no reset_nos.
